div_issue_ctrl: RTL and testbench

- Controller that sequences the two shared AXI-stream divider cores (signed and unsigned) on behalf of the EXE stage.
- Accepts one divide/modulo request at a time and issues operands to the selected core.
- Tracks each operand channel's handshake independently, captures the 64-bit core output and holds the selected 32-bit result until EXE consumes it.
- Supports pipeline flush mid-operation by draining and discarding any in-flight result.

---
 rtl/div_issue_ctrl_pkg.sv | 28 ++
 rtl/div_issue_ctrl_chk.sv | 30 +++
 rtl/div_operand_chan.sv | 35 +++
 rtl/div_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: op bit positions,
// controller state encodings and small op-decode helpers.
package div_issue_ctrl_pkg;

    // Bit positions inside the one-hot req_op vector {div_w, mod_w, div_wu, mod_wu}
    localparam int DIVOP_DIV_W  = 3;
    localparam int DIVOP_MOD_W  = 2;
    localparam int DIVOP_DIV_WU = 1;
    localparam int DIVOP_MOD_WU = 0;

    // Controller state encodings
    localparam logic [2:0] DIV_IDLE  = 3'd0;
    localparam logic [2:0] DIV_ISSUE = 3'd1;
    localparam logic [2:0] DIV_WAIT  = 3'd2;
    localparam logic [2:0] DIV_DONE  = 3'd3;
    localparam logic [2:0] DIV_DRAIN = 3'd4;

    // Signed ops go to the signed core
    function automatic logic op_is_signed(input logic [3:0] op);
        return op[DIVOP_DIV_W] | op[DIVOP_MOD_W];
    endfunction

    // Divide ops return the quotient, modulo ops the remainder
    function automatic logic op_is_quot(input logic [3:0] op);
        return op[DIVOP_DIV_W] | op[DIVOP_DIV_WU];
    endfunction

endpackage

// File: rtl/div_issue_ctrl_chk.sv
// Protocol checker for the divider issue controller.
module div_issue_ctrl_chk
    import div_issue_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] state,
    input  logic       req_valid,
    input  logic [3:0] req_op,
    input  logic       flush,
    input  logic       drop,
    input  logic       dvd_tvalid,
    input  logic       dvd_tready,
    input  logic       dvs_tvalid,
    input  logic       dvs_tready
);

    // A request taken in IDLE must carry exactly one op bit
    a_legal_op: assert property (@(posedge clk) disable iff (!resetn)
        (state == DIV_IDLE && req_valid && !flush) |-> $onehot(req_op));

    // An offered dividend stays offered until accepted or abandoned
    a_dvd_hold: assert property (@(posedge clk) disable iff (!resetn)
        (dvd_tvalid && !dvd_tready && !drop) |=> dvd_tvalid);

    // An offered divisor stays offered until accepted or abandoned
    a_dvs_hold: assert property (@(posedge clk) disable iff (!resetn)
        (dvs_tvalid && !dvs_tready && !drop) |=> dvs_tvalid);

endmodule

// File: rtl/div_operand_chan.sv
// One operand channel handshake tracker: holds tvalid from request load until
// the core accepts the operand, or until the operation is abandoned.
module div_operand_chan (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic drop,
    input  logic tready,
    output logic tvalid,
    output logic hs
);

    logic pend_r;
    logic hs_s;

    assign hs_s   = pend_r & tready;
    assign hs     = hs_s;
    assign tvalid = pend_r;

    // Pending flag: set on load, cleared by the handshake or an abandon
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_r <= 1'b0;
        end else if (drop) begin
            pend_r <= 1'b0;
        end else if (load) begin
            pend_r <= 1'b1;
        end else if (hs_s) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_r;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Divider issue controller: sequences one divide/modulo op at a time through
// the shared signed/unsigned AXI-stream divider cores and holds the result
// for EXE. A flush drains any in-flight core operation and discards it.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [DATA_W-1:0]   req_src1,
    input  logic [DATA_W-1:0]   req_src2,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_result,
    input  logic                flush,
    output logic                busy,
    output logic                s_dividend_tvalid,
    output logic                s_divisor_tvalid,
    output logic [DATA_W-1:0]   s_dividend_tdata,
    output logic [DATA_W-1:0]   s_divisor_tdata,
    output logic                sel_signed,
    input  logic                s_dividend_tready_s,
    input  logic                s_divisor_tready_s,
    input  logic                s_dividend_tready_u,
    input  logic                s_divisor_tready_u,
    input  logic                m_dout_tvalid_s,
    input  logic                m_dout_tvalid_u,
    input  logic [2*DATA_W-1:0] m_dout_tdata_s,
    input  logic [2*DATA_W-1:0] m_dout_tdata_u
);

    logic [2:0]          state_r, state_nxt_s;
    logic [DATA_W-1:0]   dvd_r, dvs_r, result_r;
    logic                sel_signed_r, quot_r;
    logic                resp_valid_r, busy_r, req_ready_r;

    logic                dvd_tready_s, dvs_tready_s, dout_valid_s;
    logic [2*DATA_W-1:0] dout_data_s;
    logic                dvd_pend_s, dvs_pend_s, dvd_hs_s, dvs_hs_s;
    logic                load_s, drop_s, ops_done_s, capture_s;

    // Route the selected core's handshake and result signals
    always_comb begin
        if (sel_signed_r) begin
            dvd_tready_s = s_dividend_tready_s;
            dvs_tready_s = s_divisor_tready_s;
            dout_valid_s = m_dout_tvalid_s;
            dout_data_s  = m_dout_tdata_s;
        end else begin
            dvd_tready_s = s_dividend_tready_u;
            dvs_tready_s = s_divisor_tready_u;
            dout_valid_s = m_dout_tvalid_u;
            dout_data_s  = m_dout_tdata_u;
        end
    end

    // A new op is taken only in IDLE; a simultaneous flush cancels it
    assign load_s     = (state_r == DIV_IDLE) & req_valid & ~flush;
    // Flush in ISSUE with neither operand ever accepted: core never started
    assign drop_s     = (state_r == DIV_ISSUE) & flush &
                        dvd_pend_s & ~dvd_hs_s & dvs_pend_s & ~dvs_hs_s;
    // Both operands accepted by the end of this cycle
    assign ops_done_s = (~dvd_pend_s | dvd_hs_s) & (~dvs_pend_s | dvs_hs_s);
    assign capture_s  = (state_r == DIV_WAIT) & dout_valid_s & ~flush;

    div_operand_chan u_dvd_chan (
        .clk    (clk),
        .resetn (resetn),
        .load   (load_s),
        .drop   (drop_s),
        .tready (dvd_tready_s),
        .tvalid (dvd_pend_s),
        .hs     (dvd_hs_s)
    );

    div_operand_chan u_dvs_chan (
        .clk    (clk),
        .resetn (resetn),
        .load   (load_s),
        .drop   (drop_s),
        .tready (dvs_tready_s),
        .tvalid (dvs_pend_s),
        .hs     (dvs_hs_s)
    );

    // Next-state selection; flush outranks every other transition
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (load_s) state_nxt_s = DIV_ISSUE;
                else        state_nxt_s = DIV_IDLE;
            end
            DIV_ISSUE: begin
                if (flush)           state_nxt_s = drop_s ? DIV_IDLE : DIV_DRAIN;
                else if (ops_done_s) state_nxt_s = DIV_WAIT;
                else                 state_nxt_s = DIV_ISSUE;
            end
            DIV_WAIT: begin
                if (flush)             state_nxt_s = dout_valid_s ? DIV_IDLE : DIV_DRAIN;
                else if (dout_valid_s) state_nxt_s = DIV_DONE;
                else                   state_nxt_s = DIV_WAIT;
            end
            DIV_DONE: begin
                if (flush || resp_ready) state_nxt_s = DIV_IDLE;
                else                     state_nxt_s = DIV_DONE;
            end
            DIV_DRAIN: begin
                // Result only exists once both operands have been taken
                if (!dvd_pend_s && !dvs_pend_s && dout_valid_s) state_nxt_s = DIV_IDLE;
                else                                            state_nxt_s = DIV_DRAIN;
            end
            default: state_nxt_s = DIV_IDLE;
        endcase
    end

    // State, operand/result capture and registered status outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= DIV_IDLE;
            dvd_r        <= {DATA_W{1'b0}};
            dvs_r        <= {DATA_W{1'b0}};
            result_r     <= {DATA_W{1'b0}};
            sel_signed_r <= 1'b0;
            quot_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            req_ready_r  <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            resp_valid_r <= (state_nxt_s == DIV_DONE);
            busy_r       <= (state_nxt_s != DIV_IDLE);
            req_ready_r  <= (state_nxt_s == DIV_IDLE);
            if (load_s) begin
                dvd_r        <= req_src1;
                dvs_r        <= req_src2;
                sel_signed_r <= op_is_signed(req_op);
                quot_r       <= op_is_quot(req_op);
            end
            if (capture_s) begin
                result_r <= quot_r ? dout_data_s[2*DATA_W-1:DATA_W] : dout_data_s[DATA_W-1:0];
            end
        end
    end

    assign req_ready         = req_ready_r;
    assign resp_valid        = resp_valid_r;
    assign resp_result       = result_r;
    assign busy              = busy_r;
    assign s_dividend_tvalid = dvd_pend_s;
    assign s_divisor_tvalid  = dvs_pend_s;
    assign s_dividend_tdata  = dvd_r;
    assign s_divisor_tdata   = dvs_r;
    assign sel_signed        = sel_signed_r;

    div_issue_ctrl_chk u_chk (
        .clk        (clk),
        .resetn     (resetn),
        .state      (state_r),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .flush      (flush),
        .drop       (drop_s),
        .dvd_tvalid (dvd_pend_s),
        .dvd_tready (dvd_tready_s),
        .dvs_tvalid (dvs_pend_s),
        .dvs_tready (dvs_tready_s)
    );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed scenarios plus randomized ops, checked
// against a transaction-level model of the controller's observable behaviour.
module tb_div_issue_ctrl;

    localparam int DW = 32;
    localparam logic [3:0] OP_DIV_W  = 4'b1000;
    localparam logic [3:0] OP_MOD_W  = 4'b0100;
    localparam logic [3:0] OP_DIV_WU = 4'b0010;
    localparam logic [3:0] OP_MOD_WU = 4'b0001;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0, req_ready;
    logic [3:0]    req_op = 4'd0;
    logic [DW-1:0] req_src1 = '0, req_src2 = '0;
    logic          resp_valid, resp_ready = 1'b0;
    logic [DW-1:0] resp_result;
    logic          flush = 1'b0, busy;
    logic          s_dividend_tvalid, s_divisor_tvalid;
    logic [DW-1:0] s_dividend_tdata, s_divisor_tdata;
    logic          sel_signed;
    logic          s_dividend_tready_s = 1'b0, s_divisor_tready_s = 1'b0;
    logic          s_dividend_tready_u = 1'b0, s_divisor_tready_u = 1'b0;
    logic          m_dout_tvalid_s = 1'b0, m_dout_tvalid_u = 1'b0;
    logic [2*DW-1:0] m_dout_tdata_s = '0, m_dout_tdata_u = '0;

    int n_tests = 0;
    int n_fail  = 0;

    div_issue_ctrl #(.DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .flush(flush), .busy(busy),
        .s_dividend_tvalid(s_dividend_tvalid), .s_divisor_tvalid(s_divisor_tvalid),
        .s_dividend_tdata(s_dividend_tdata), .s_divisor_tdata(s_divisor_tdata),
        .sel_signed(sel_signed),
        .s_dividend_tready_s(s_dividend_tready_s), .s_divisor_tready_s(s_divisor_tready_s),
        .s_dividend_tready_u(s_dividend_tready_u), .s_divisor_tready_u(s_divisor_tready_u),
        .m_dout_tvalid_s(m_dout_tvalid_s), .m_dout_tvalid_u(m_dout_tvalid_u),
        .m_dout_tdata_s(m_dout_tdata_s), .m_dout_tdata_u(m_dout_tdata_u)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Divider core behaviour: {quotient, remainder}; divide by zero gives
    // all-ones quotient and the dividend as remainder
    function automatic logic [63:0] core_dout(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic idle_inputs();
        s_dividend_tready_s = 1'b0; s_divisor_tready_s = 1'b0;
        s_dividend_tready_u = 1'b0; s_divisor_tready_u = 1'b0;
        m_dout_tvalid_s = 1'b0; m_dout_tvalid_u = 1'b0;
        flush = 1'b0; resp_ready = 1'b0;
    endtask

    // One op from request to return to idle. Delays are in cycles after the
    // request is taken; flush_at < 0 means no flush.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int dvd_dly, input int dvs_dly,
                          input int lat, input int flush_at, input int rdly,
                          output logic [31:0] got);
        logic        sgn, quot, trdy_d, trdy_v, fire, rr, hs_d, hs_v, in_issue, in_wait;
        logic [63:0] dout;
        logic [31:0] exp_res;
        bit dvd_seen = 0, dvs_seen = 0, dropped = 0, draining = 0;
        bit dout_done = 0, resp_pend = 0, fin = 0;
        int lat_cnt, rwait, k;
        sgn     = (op == OP_DIV_W) || (op == OP_MOD_W);
        quot    = (op == OP_DIV_W) || (op == OP_DIV_WU);
        dout    = core_dout(sgn, a, b);
        exp_res = quot ? dout[63:32] : dout[31:0];
        got     = 32'd0;
        lat_cnt = lat;
        rwait   = 0;
        chk({name, "_ready_in"}, 64'(req_ready), 64'(1'b1));
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
        step();
        req_valid = 1'b0; req_op = 4'd0; req_src1 = $urandom; req_src2 = $urandom;
        chk({name, "_dvd_data"}, 64'(s_dividend_tdata), 64'(a));
        chk({name, "_dvs_data"}, 64'(s_divisor_tdata), 64'(b));
        chk({name, "_sel"}, 64'(sel_signed), 64'(sgn));
        k = 0;
        while (1) begin
            chk({name, "_dvd_valid"}, 64'(s_dividend_tvalid), 64'(!dvd_seen && !dropped));
            chk({name, "_dvs_valid"}, 64'(s_divisor_tvalid), 64'(!dvs_seen && !dropped));
            chk({name, "_resp_valid"}, 64'(resp_valid), 64'(resp_pend));
            if (resp_pend) begin
                chk({name, "_result"}, 64'(resp_result), 64'(exp_res));
                got = resp_result;
            end
            chk({name, "_req_ready"}, 64'(req_ready), 64'(fin));
            chk({name, "_busy"}, 64'(busy), 64'(!fin));
            if (fin) break;
            if (k == 80) begin
                chk({name, "_timeout"}, 64'(1'b0), 64'(1'b1));
                break;
            end
            trdy_d = (k >= dvd_dly);
            trdy_v = (k >= dvs_dly);
            in_issue = !(dvd_seen && dvs_seen) && !dropped;
            in_wait  = dvd_seen && dvs_seen && !dout_done;
            fire = in_wait && (lat_cnt == 0);
            if (in_wait && lat_cnt > 0) lat_cnt--;
            if (sgn) begin
                s_dividend_tready_s = trdy_d; s_divisor_tready_s = trdy_v;
                s_dividend_tready_u = 1'($urandom_range(0, 1));
                s_divisor_tready_u  = 1'($urandom_range(0, 1));
                m_dout_tvalid_s = fire;
                m_dout_tdata_s  = fire ? dout : {$urandom, $urandom};
                m_dout_tvalid_u = 1'($urandom_range(0, 1));
                m_dout_tdata_u  = {$urandom, $urandom};
            end else begin
                s_dividend_tready_u = trdy_d; s_divisor_tready_u = trdy_v;
                s_dividend_tready_s = 1'($urandom_range(0, 1));
                s_divisor_tready_s  = 1'($urandom_range(0, 1));
                m_dout_tvalid_u = fire;
                m_dout_tdata_u  = fire ? dout : {$urandom, $urandom};
                m_dout_tvalid_s = 1'($urandom_range(0, 1));
                m_dout_tdata_s  = {$urandom, $urandom};
            end
            flush = (k == flush_at);
            rr = resp_pend && (rwait >= rdly);
            if (resp_pend) rwait++;
            resp_ready = resp_pend ? rr : 1'($urandom_range(0, 1));
            step();
            hs_d = !dvd_seen && !dropped && trdy_d;
            hs_v = !dvs_seen && !dropped && trdy_v;
            if (flush && !draining) begin
                if (resp_pend) begin
                    resp_pend = 0; fin = 1;
                end else if (in_issue) begin
                    if (!dvd_seen && !dvs_seen && !hs_d && !hs_v) begin
                        dropped = 1; fin = 1;
                    end else begin
                        draining = 1;
                    end
                end else if (in_wait) begin
                    if (fire) fin = 1;
                    else      draining = 1;
                end
            end else if (fire) begin
                if (draining) fin = 1;
                else          resp_pend = 1;
            end else if (resp_pend && rr) begin
                resp_pend = 0; fin = 1;
            end
            if (fire) dout_done = 1;
            if (hs_d) dvd_seen = 1;
            if (hs_v) dvs_seen = 1;
            k++;
        end
        idle_inputs();
    endtask

    initial begin
        logic [31:0] got, a, b;
        logic [3:0]  op;
        int fl;

        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        chk("rst_req_ready", 64'(req_ready), 64'(1'b1));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(1'b0));
        chk("rst_dvd_valid", 64'(s_dividend_tvalid), 64'(1'b0));
        chk("rst_dvs_valid", 64'(s_divisor_tvalid), 64'(1'b0));
        chk("rst_result", 64'(resp_result), 64'(32'd0));
        resetn = 1'b1;
        step();

        run_op("sdiv", OP_DIV_W, 32'hFFFF_FFF9, 32'd2, 0, 0, 8, -1, 3, got);
        chk("sdiv_value", 64'(got), 64'(32'hFFFF_FFFD));
        run_op("smod_stag", OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 0, 3, 4, -1, 0, got);
        chk("smod_value", 64'(got), 64'(32'hFFFF_FFFF));
        run_op("udiv", OP_DIV_WU, 32'hFFFF_FFF9, 32'd2, 1, 0, 5, -1, 1, got);
        chk("udiv_value", 64'(got), 64'(32'h7FFF_FFFC));
        run_op("umod", OP_MOD_WU, 32'hFFFF_FFF9, 32'd2, 0, 0, 3, -1, 2, got);
        chk("umod_value", 64'(got), 64'(32'h0000_0001));
        run_op("fl_wait", OP_DIV_W, 32'd100, 32'd7, 0, 0, 8, 3, 0, got);
        run_op("after_fl", OP_DIV_WU, 32'd10, 32'd3, 0, 0, 2, -1, 0, got);
        chk("after_fl_value", 64'(got), 64'(32'd3));
        run_op("fl_issue", OP_MOD_W, 32'd55, 32'd4, 5, 5, 2, 1, 0, got);
        run_op("fl_half", OP_DIV_WU, 32'd55, 32'd4, 0, 4, 2, 2, 0, got);
        run_op("fl_done", OP_MOD_WU, 32'd55, 32'd4, 0, 0, 2, 5, 10, got);
        run_op("fl_dout", OP_DIV_W, 32'd55, 32'd4, 0, 0, 0, 1, 0, got);
        run_op("div0", OP_DIV_W, 32'd1234, 32'd0, 0, 0, 1, -1, 0, got);
        chk("div0_value", 64'(got), 64'(32'hFFFF_FFFF));

        // Reset while the op waits for the core
        req_valid = 1'b1; req_op = OP_DIV_W; req_src1 = 32'd7; req_src2 = 32'd1;
        step();
        req_valid = 1'b0; req_op = 4'd0;
        s_dividend_tready_s = 1'b1; s_divisor_tready_s = 1'b1;
        step();
        idle_inputs();
        step();
        chk("rw_busy_pre", 64'(busy), 64'(1'b1));
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("rw_req_ready", 64'(req_ready), 64'(1'b1));
        chk("rw_busy", 64'(busy), 64'(1'b0));
        chk("rw_dvd_valid", 64'(s_dividend_tvalid), 64'(1'b0));
        chk("rw_result", 64'(resp_result), 64'(32'd0));
        chk("rw_dvd_data", 64'(s_dividend_tdata), 64'(32'd0));
        chk("rw_sel", 64'(sel_signed), 64'(1'b0));
        m_dout_tvalid_s = 1'b1; m_dout_tdata_s = {$urandom, $urandom};
        m_dout_tvalid_u = 1'b1; m_dout_tdata_u = {$urandom, $urandom};
        step();
        idle_inputs();
        step();
        chk("stale_resp_valid", 64'(resp_valid), 64'(1'b0));
        chk("stale_busy", 64'(busy), 64'(1'b0));
        chk("stale_req_ready", 64'(req_ready), 64'(1'b1));

        // Randomized ops with random handshake timing and occasional flushes
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_DIV_W;
                1:       op = OP_MOD_W;
                2:       op = OP_DIV_WU;
                default: op = OP_MOD_WU;
            endcase
            a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
            b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1;
            run_op("rand", op, a, b, $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 8), fl, $urandom_range(0, 3), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
